// File: rtl/sep_sum_pkg.sv
// -----------------------------------------------------------------------------
// sep_sum_pkg
// Shared constants and types for the separate_sum column: the controller FSM
// state encoding, the fixed sum-pipeline latency (also used by
// separate_sum_unit) and default geometry of the weight chain / tile command.
// -----------------------------------------------------------------------------
package sep_sum_pkg;

    // Fixed depth of the separate_sum_unit arithmetic pipeline.
    localparam int PIPE_LATENCY = 3;

    // Default column geometry.
    localparam int CHAIN_DEPTH_DEFAULT    = 8;
    localparam int TILE_LEN_WIDTH_DEFAULT = 8;

    // Controller state encoding.
    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_LOAD_ENC  = 3'd1;
    localparam logic [2:0] ST_SET_ENC   = 3'd2;
    localparam logic [2:0] ST_RUN_ENC   = 3'd3;
    localparam logic [2:0] ST_DRAIN_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_LOAD  = ST_LOAD_ENC,
        ST_SET   = ST_SET_ENC,
        ST_RUN   = ST_RUN_ENC,
        ST_DRAIN = ST_DRAIN_ENC
    } state_t;

endpackage

// File: rtl/separate_sum_ctrl_if.sv
// -----------------------------------------------------------------------------
// separate_sum_ctrl_if
// Bundles the command, weight-chain, activation and result signals of the
// separate_sum_ctrl sequencer.
//   slave  : the controller's view (accepts commands/beats, drives the column)
//   master : the environment's view (scheduler, chain source, result sink)
// Signals:
//   cmd_valid_i/cmd_ready_o/cmd_tile_len_i  command handshake + tile length
//   abort_i                                 abort of the current command
//   wgt_valid_i/wgt_ready_o                 weight-beat handshake
//   prepare_weight_o/set_weight_o           chain shift enable / commit pulse
//   act_valid_i/act_ready_o                 activation-beat handshake
//   result_valid_o/result_last_o            sum output qualifiers
//   busy_o/done_o/aborted_o                 status
// -----------------------------------------------------------------------------
interface separate_sum_ctrl_if #(
    parameter int TILE_LEN_WIDTH = sep_sum_pkg::TILE_LEN_WIDTH_DEFAULT
);
    logic                      cmd_valid_i;
    logic                      cmd_ready_o;
    logic [TILE_LEN_WIDTH-1:0] cmd_tile_len_i;
    logic                      abort_i;
    logic                      wgt_valid_i;
    logic                      wgt_ready_o;
    logic                      prepare_weight_o;
    logic                      set_weight_o;
    logic                      act_valid_i;
    logic                      act_ready_o;
    logic                      result_valid_o;
    logic                      result_last_o;
    logic                      busy_o;
    logic                      done_o;
    logic                      aborted_o;

    modport slave (
        input  cmd_valid_i, cmd_tile_len_i, abort_i, wgt_valid_i, act_valid_i,
        output cmd_ready_o, wgt_ready_o, prepare_weight_o, set_weight_o,
               act_ready_o, result_valid_o, result_last_o, busy_o, done_o,
               aborted_o
    );

    modport master (
        output cmd_valid_i, cmd_tile_len_i, abort_i, wgt_valid_i, act_valid_i,
        input  cmd_ready_o, wgt_ready_o, prepare_weight_o, set_weight_o,
               act_ready_o, result_valid_o, result_last_o, busy_o, done_o,
               aborted_o
    );
endinterface

// File: rtl/valid_delay_line.sv
// -----------------------------------------------------------------------------
// valid_delay_line
// DEPTH-stage shift register for the {valid,last} qualifiers that shadow the
// separate_sum_unit pipeline. Shifts every cycle (bubbles are shifted in as 0).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_last   qualifiers entering stage 0
//   out_valid, out_last registered tail (last stage)
//   empty               no valid bit anywhere, tail included
// -----------------------------------------------------------------------------
module valid_delay_line #(
    parameter int DEPTH = sep_sum_pkg::PIPE_LATENCY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last,
    output logic empty
);
    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] last_reg;
    logic [DEPTH-1:0] valid_next;
    logic [DEPTH-1:0] last_next;

    assign valid_next[0] = in_valid;
    assign last_next[0]  = in_last;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
            assign valid_next[gi] = valid_reg[gi-1];
            assign last_next[gi]  = last_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            last_reg  <= '0;
        end else begin
            valid_reg <= valid_next;
            last_reg  <= last_next;
        end
    end

    assign out_valid = valid_reg[DEPTH-1];
    assign out_last  = last_reg[DEPTH-1];
    assign empty     = ~|valid_reg;
endmodule

// File: rtl/separate_sum_ctrl.sv
// -----------------------------------------------------------------------------
// separate_sum_ctrl
// Sequencer for one column of separate_sum_unit instances. Per command:
// shift CHAIN_DEPTH weight beats through the chain (prepare_weight_o), commit
// them with one set_weight_o pulse, stream tile_len activation beats, then
// wait for the PIPE_LATENCY-deep sum pipeline to empty and pulse done_o.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         separate_sum_ctrl_if.slave (command, weight, activation,
//               result and status signals)
// -----------------------------------------------------------------------------
module separate_sum_ctrl #(
    parameter int CHAIN_DEPTH    = sep_sum_pkg::CHAIN_DEPTH_DEFAULT,
    parameter int TILE_LEN_WIDTH = sep_sum_pkg::TILE_LEN_WIDTH_DEFAULT,
    parameter int PIPE_LATENCY   = sep_sum_pkg::PIPE_LATENCY
) (
    input  logic                clk,
    input  logic                rst_n,
    separate_sum_ctrl_if.slave  bus
);
    import sep_sum_pkg::*;

    localparam int LOAD_CNT_WIDTH = (CHAIN_DEPTH > 1) ? $clog2(CHAIN_DEPTH) : 1;
    localparam logic [LOAD_CNT_WIDTH-1:0] LOAD_LAST = LOAD_CNT_WIDTH'(CHAIN_DEPTH - 1);
    localparam logic [TILE_LEN_WIDTH-1:0] REM_ONE   = TILE_LEN_WIDTH'(1);

    state_t                    state_reg,     state_next;
    logic [LOAD_CNT_WIDTH-1:0] load_cnt_reg,  load_cnt_next;
    logic [TILE_LEN_WIDTH-1:0] remaining_reg, remaining_next;
    logic                      aborted_reg,   aborted_next;
    logic                      done_reg,      done_next;

    logic wgt_ready;
    logic act_ready;
    logic set_weight;
    logic push_valid;
    logic push_last;
    logic pipe_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            load_cnt_reg  <= '0;
            remaining_reg <= '0;
            aborted_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            load_cnt_reg  <= load_cnt_next;
            remaining_reg <= remaining_next;
            aborted_reg   <= aborted_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        load_cnt_next  = load_cnt_reg;
        remaining_next = remaining_reg;
        aborted_next   = aborted_reg;
        done_next      = 1'b0;
        wgt_ready      = 1'b0;
        act_ready      = 1'b0;
        set_weight     = 1'b0;
        push_valid     = 1'b0;
        push_last      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.cmd_valid_i) begin
                    remaining_next = bus.cmd_tile_len_i;
                    load_cnt_next  = '0;
                    aborted_next   = 1'b0;
                    state_next     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                wgt_ready = ~bus.abort_i;
                if (bus.abort_i) begin
                    aborted_next = 1'b1;
                    state_next   = ST_DRAIN;
                end else if (bus.wgt_valid_i) begin
                    // Leave on the terminal beat instead of wrapping the count.
                    if (load_cnt_reg == LOAD_LAST) begin
                        state_next = ST_SET;
                    end else begin
                        load_cnt_next = load_cnt_reg + LOAD_CNT_WIDTH'(1);
                    end
                end
            end
            ST_SET: begin
                if (bus.abort_i) begin
                    aborted_next = 1'b1;
                    state_next   = ST_DRAIN;
                end else begin
                    set_weight = 1'b1;
                    state_next = (remaining_reg != '0) ? ST_RUN : ST_DRAIN;
                end
            end
            ST_RUN: begin
                act_ready = ~bus.abort_i;
                if (bus.abort_i) begin
                    aborted_next = 1'b1;
                    state_next   = ST_DRAIN;
                end else if (bus.act_valid_i) begin
                    push_valid     = 1'b1;
                    push_last      = (remaining_reg == REM_ONE);
                    remaining_next = remaining_reg - REM_ONE;
                    if (remaining_reg == REM_ONE) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    valid_delay_line #(
        .DEPTH (PIPE_LATENCY)
    ) u_valid_delay_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push_valid),
        .in_last   (push_last),
        .out_valid (bus.result_valid_o),
        .out_last  (bus.result_last_o),
        .empty     (pipe_empty)
    );

    assign bus.cmd_ready_o      = (state_reg == ST_IDLE);
    assign bus.busy_o           = (state_reg != ST_IDLE);
    assign bus.wgt_ready_o      = wgt_ready;
    assign bus.act_ready_o      = act_ready;
    assign bus.prepare_weight_o = bus.wgt_valid_i & wgt_ready;
    assign bus.set_weight_o     = set_weight;
    assign bus.done_o           = done_reg;
    assign bus.aborted_o        = aborted_reg;
endmodule
